// File: rtl/pin_update_master_pkg.sv
// Shared word format, coefficient ordering and broadcast FSM states for the
// pin-update master and its D-CFIR slaves.
package pin_update_master_pkg;

    localparam int SDI_W           = 23;
    localparam int SID_LSB         = 18;
    localparam int SID_W           = 5;
    localparam int CIDX_LSB        = 15;
    localparam int CIDX_W          = 3;
    localparam int PAD_LSB         = 10;
    localparam int PAD_W           = 5;
    localparam int DATA_W          = 10;
    localparam int NUM_COE_DEFAULT = 6;

    typedef enum logic [CIDX_W-1:0] {
        COE0_REAL = 3'd0,
        COE1_REAL = 3'd1,
        COE2_REAL = 3'd2,
        COE0_IMAG = 3'd3,
        COE1_IMAG = 3'd4,
        COE2_IMAG = 3'd5
    } coe_idx_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        GAP  = 3'd2,
        LOAD = 3'd3,
        FIN  = 3'd4
    } state_e;

    function automatic logic [SDI_W-1:0] pack_word(input logic [SID_W-1:0]  sid,
                                                   input logic [CIDX_W-1:0] cidx,
                                                   input logic [DATA_W-1:0] data);
        logic [SDI_W-1:0] w;
        w = '0;
        w[SID_LSB +: SID_W]   = sid;
        w[CIDX_LSB +: CIDX_W] = cidx;
        w[0 +: DATA_W]        = data;
        return w;
    endfunction

endpackage

// File: rtl/pin_update_master_coe_shadow_table.sv
// Host-writable shadow copy of every slave coefficient; synchronous write,
// combinational read. Out-of-range indices read zero and never write.
module coe_shadow_table #(
    parameter int DEPTH  = 24,
    parameter int DATA_W = 10
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              we,
    input  logic [7:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int         AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] LIMIT = 9'(DEPTH);

    logic [DATA_W-1:0] mem [2**AW];
    logic              w_in, r_in;

    assign w_in = ({1'b0, waddr} < LIMIT);
    assign r_in = ({1'b0, raddr} < LIMIT);

    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else if (we && w_in) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = r_in ? mem[raddr[AW-1:0]] : '0;

endmodule

// File: rtl/pin_update_slave.sv
// D-CFIR slave front end: captures words addressed to SLAVE_ID into a pending
// bank and moves the whole bank to interp_coe on the coe_load pulse.
module pin_update_slave
    import pin_update_master_pkg::*;
#(
    parameter int SLAVE_ID = 0,
    parameter int NUM_COE  = NUM_COE_DEFAULT
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      ssb,
    input  logic [SDI_W-1:0]          sdi,
    input  logic                      coe_load,
    output logic [NUM_COE*DATA_W-1:0] interp_coe
);
    logic [DATA_W-1:0] pend [NUM_COE];
    logic [DATA_W-1:0] act  [NUM_COE];
    logic              hit;
    logic [CIDX_W-1:0] cidx;

    assign cidx = sdi[CIDX_LSB +: CIDX_W];
    // Malformed words (non-zero pad) are dropped rather than half-applied.
    assign hit  = !ssb && (sdi[SID_LSB +: SID_W] == SID_W'(SLAVE_ID))
                       && (sdi[PAD_LSB +: PAD_W] == '0)
                       && (32'(cidx) < NUM_COE);

    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < NUM_COE; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
            end
        end else begin
            if (hit) pend[cidx] <= sdi[0 +: DATA_W];
            if (coe_load) act <= pend;
        end
    end

    always_comb begin
        interp_coe = '0;
        for (int i = 0; i < NUM_COE; i++) interp_coe[i*DATA_W +: DATA_W] = act[i];
    end

endmodule

// File: rtl/pin_update_master.sv
// Broadcasts the coefficient shadow table to all slaves one word per cycle,
// then a one-cycle gap, a coe_load commit pulse and a done pulse.
module pin_update_master
    import pin_update_master_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int NUM_COE    = NUM_COE_DEFAULT
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_addr,
    input  logic [9:0]       wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             wr_err,
    output logic             ssb,
    output logic [SDI_W-1:0] sdi,
    output logic             coe_load
);
    localparam int         DEPTH = NUM_SLAVES * NUM_COE;
    localparam logic [8:0] LIMIT = 9'(DEPTH);

    state_e            state;
    logic [5:0]        slv;
    logic [2:0]        coe;
    logic              wr_ok, last_coe, sent_all, emit;
    logic [7:0]        rd_addr;
    logic [9:0]        tbl_data, rd_data;
    logic [SDI_W-1:0]  word;

    assign wr_ok    = wr_en && !busy && ({1'b0, wr_addr} < LIMIT);
    assign rd_addr  = 8'(32'(slv) * NUM_COE + 32'(coe));
    assign last_coe = (coe == 3'(NUM_COE - 1));
    assign sent_all = (slv == 6'(NUM_SLAVES));
    assign emit     = ((state == IDLE) && start) || ((state == SEND) && !sent_all);

    coe_shadow_table #(
        .DEPTH  (DEPTH),
        .DATA_W (10)
    ) u_table (
        .CLK   (CLK),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (tbl_data)
    );

    // A write landing on the same edge as start must reach the first word.
    assign rd_data = (wr_ok && (wr_addr == rd_addr)) ? wr_data : tbl_data;
    assign word    = pack_word(slv[4:0], coe, rd_data);

    always_ff @(posedge CLK) begin
        if (rst) begin
            state    <= IDLE;
            slv      <= '0;
            coe      <= '0;
            ssb      <= 1'b1;
            sdi      <= '0;
            coe_load <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            wr_err   <= wr_en && !wr_ok;
            coe_load <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= SEND;
                    busy  <= 1'b1;
                end
                SEND: if (sent_all) begin
                    state <= GAP;
                    ssb   <= 1'b1;
                    sdi   <= '0;
                    slv   <= '0;
                    coe   <= '0;
                end
                GAP: begin
                    state    <= LOAD;
                    coe_load <= 1'b1;
                end
                LOAD: begin
                    state <= FIN;
                    done  <= 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (emit) begin
                ssb <= 1'b0;
                sdi <= word;
                coe <= last_coe ? 3'd0 : coe + 3'd1;
                slv <= last_coe ? slv + 6'd1 : slv;
            end
        end
    end

endmodule

// File: doc/pin_update_master.md
PIN_UPDATE_MASTER -- requirements
Module: pin_update_master

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4 (range 1..32), giving the number of D-CFIR slaves served.
REQ-002 SHALL have parameter NUM_COE, default 6, giving coefficients per slave, ordered coe0_real, coe1_real, coe2_real, coe0_imag, coe1_imag, coe2_imag.
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_en  input  1  host write strobe into the shadow table.
REQ-006 SHALL have port wr_addr  input  8  table index = slave_id*NUM_COE + coe_idx.
REQ-007 SHALL have port wr_data  input  10  signed two's-complement coefficient.
REQ-008 SHALL have port start  input  1  single-cycle request to broadcast the full table.
REQ-009 SHALL have port busy  output  1  high while a broadcast is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at broadcast completion.
REQ-011 SHALL have port wr_err  output  1  one-cycle pulse when a write is rejected.
REQ-012 SHALL have port ssb  output  1  active-low word strobe to slaves.
REQ-013 SHALL have port sdi  output  23  serial-data word bus to slaves.
REQ-014 SHALL have port coe_load  output  1  one-cycle commit pulse to all slaves.

Function
REQ-015 SHALL format each sdi word as [22:18] slave_id, [17:15] coe_idx, [14:10] zero, [9:0] coefficient.
REQ-016 SHALL drive sdi to all-zero whenever ssb is high.
REQ-017 SHALL use FSM states IDLE, SEND, GAP, LOAD, FIN; IDLE->SEND on start, SEND->GAP after the last word, GAP->LOAD, LOAD->FIN, FIN->IDLE, each after one cycle.
REQ-018 SHALL, with start sampled in cycle 0, emit words in cycles 1..NUM_SLAVES*NUM_COE, one per cycle, with ssb low in every such cycle; order: slave 0 first, coe_idx 0..5 within each slave.
REQ-019 SHALL hold ssb high and coe_load low in GAP (cycle NUM_SLAVES*NUM_COE+1).
REQ-020 SHALL assert coe_load for exactly one cycle in LOAD (cycle NUM_SLAVES*NUM_COE+2).
REQ-021 SHALL pulse done in FIN (cycle NUM_SLAVES*NUM_COE+3); busy SHALL be high from cycle 1 through FIN inclusive and low otherwise.
REQ-022 SHALL ignore start while busy, with no restart and no error.
REQ-023 SHALL accept wr_en in any cycle busy is low and wr_addr < NUM_SLAVES*NUM_COE; the table SHALL update on the next edge.
REQ-024 SHALL reject wr_en while busy or with wr_addr out of range, leaving the table unchanged and pulsing wr_err the next cycle.
REQ-025 SHALL, when wr_en and start coincide in IDLE, commit the write first so the broadcast carries the new value.
REQ-026 SHALL transmit table contents unmodified (no saturation or sign change) in sdi[9:0].

Reset
REQ-027 SHALL, on rst, go to IDLE, clear the table to zero, and drive ssb=1, sdi=0, coe_load=0, busy=0, done=0, wr_err=0.
REQ-028 SHALL, on rst during a broadcast, abort without issuing coe_load, so slaves keep their active coefficients.

Structure
REQ-029 SHALL place the sdi field positions, NUM_COE, the coe_idx encoding and the FSM state enumeration in a shared package, also used by pin_update_slave.
REQ-030 SHALL implement the table as sub-module coe_shadow_table (synchronous write, combinational read by index); the FSM, word counter and sdi formatting stay in pin_update_master.

Verification
REQ-031 SHALL cover: reset, then start with an all-zero table -> 24 words with ssb low in cycles 1..24, sdi=slave_id/idx headers with zero data, coe_load in cycle 26, done in cycle 27.
REQ-032 SHALL cover: write 10'h1FF at address 0 and 10'h200 at address 23, then start -> word 1 sdi=23'h0001FF and word 24 sdi={5'd3,3'd5,5'd0,10'h200}.
REQ-033 SHALL cover: wr_en in cycle 5 of a broadcast and wr_en to address 24 -> wr_err pulses for each and the next broadcast shows no change.
REQ-034 SHALL cover: rst asserted in cycle 10 of a broadcast -> the next cycle shows ssb=1, busy=0, no coe_load, and a readback broadcast carries all-zero data.
REQ-035 SHALL cover: start re-pulsed in cycle 3, and wr_en+start coincident in IDLE -> no restart (done exactly once, at cycle 27), and the coincident write value appears in the broadcast.
REQ-036 SHALL cover: loopback into two pin_update_slave instances -> slave interp_coe outputs match the table after coe_load.
